servo_scheduler: RTL and testbench

- Frame-based scheduler that time-shares one servoDriver instance between NUM_CH servo outputs (pan/tilt for colour tracking).
- Holds a per-channel target pulse width written by the tracking logic.
- Once per FRAME_CYCLES, clamps and slew-limits each committed width, then starts the driver once per channel in order and routes the driver pulse to that channel's pin.

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_slew_limit.sv | 37 +++
 rtl/servo_scheduler.sv | 176 +++++++++++++++++
 tb/tb_servo_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and default timing for the servo frame scheduler.
// Widths are in clock cycles; defaults assume a 100 MHz clock.
package servo_pkg;

    typedef logic [31:0] pw_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_UPDATE,
        S_ISSUE,
        S_ACK,
        S_RUN
    } servo_sched_state_t;

    localparam int DEF_MIN_PW    = 100000;
    localparam int DEF_MAX_PW    = 200000;
    localparam int DEF_CENTER_PW = 150000;
    localparam int DEF_SLEW_STEP = 5000;

endpackage

// File: rtl/servo_slew_limit.sv
// Clamp a target width into [MIN_PW, MAX_PW] and move the committed
// width toward it by at most SLEW_STEP; purely combinational.
module servo_slew_limit
    import servo_pkg::*;
#(
    parameter pw_t MIN_PW    = pw_t'(DEF_MIN_PW),
    parameter pw_t MAX_PW    = pw_t'(DEF_MAX_PW),
    parameter pw_t SLEW_STEP = pw_t'(DEF_SLEW_STEP)
) (
    input  pw_t i_target,
    input  pw_t i_committed,
    output pw_t o_next
);

    pw_t w_t;
    pw_t w_diff;

    always_comb begin
        w_t    = i_target;
        w_diff = '0;
        o_next = i_committed;
        if (i_target < MIN_PW) begin
            w_t = MIN_PW;
        end else if (i_target > MAX_PW) begin
            w_t = MAX_PW;
        end
        // Subtract in the safe direction so nothing wraps.
        if (w_t >= i_committed) begin
            w_diff = w_t - i_committed;
            o_next = i_committed + ((w_diff > SLEW_STEP) ? SLEW_STEP : w_diff);
        end else begin
            w_diff = i_committed - w_t;
            o_next = i_committed - ((w_diff > SLEW_STEP) ? SLEW_STEP : w_diff);
        end
    end

endmodule

// File: rtl/servo_scheduler.sv
// Time-shares one servo driver across NUM_CH pins: once per frame each
// committed width is slew-limited, then each channel's pulse is issued in turn.
module servo_scheduler
    import servo_pkg::*;
#(
    parameter  int NUM_CH       = 2,
    parameter  int FRAME_CYCLES = 2000000,
    parameter  int MIN_PW       = DEF_MIN_PW,
    parameter  int MAX_PW       = DEF_MAX_PW,
    parameter  int CENTER_PW    = DEF_CENTER_PW,
    parameter  int SLEW_STEP    = DEF_SLEW_STEP,
    parameter  int DONE_TIMEOUT = 4,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TW           = $clog2(DONE_TIMEOUT + 1)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_enable,
    input  logic              i_pos_wr,
    input  logic [CH_W-1:0]   i_pos_ch,
    input  logic [31:0]       i_pos_data,
    output logic              o_drv_start,
    output logic [31:0]       o_drv_pulseWidth,
    input  logic              i_drv_done,
    input  logic              i_drv_pulse,
    output logic [NUM_CH-1:0] o_servo_pulse,
    output logic              o_frame_start,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_err
);

    servo_sched_state_t r_state;

    pw_t             r_target    [NUM_CH];
    pw_t             r_committed [NUM_CH];
    pw_t             w_next      [NUM_CH];
    pw_t             r_drv_pw;
    logic [31:0]     r_frame_cnt;
    logic [CH_W-1:0] r_ch;
    logic [TW-1:0]   r_timer;
    logic            r_alive;
    logic            r_drv_start;
    logic            r_overrun;
    logic            r_err;
    logic            w_tick;
    logic            w_busy;
    logic            w_last;
    logic            w_route;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slew
        servo_slew_limit #(
            .MIN_PW    (pw_t'(MIN_PW)),
            .MAX_PW    (pw_t'(MAX_PW)),
            .SLEW_STEP (pw_t'(SLEW_STEP))
        ) u_slew (
            .i_target    (r_target[g]),
            .i_committed (r_committed[g]),
            .o_next      (w_next[g])
        );
    end

    // r_alive keeps the tick strobe quiet while reset is held.
    assign w_tick  = i_enable && r_alive && (r_frame_cnt == '0);
    assign w_busy  = !((r_state == S_IDLE) || (r_state == S_WAIT_FRAME));
    assign w_last  = (r_ch == CH_W'(NUM_CH - 1)) || !i_enable;
    assign w_route = (r_state == S_ACK) || (r_state == S_RUN);

    assign o_frame_start    = w_tick;
    assign o_busy           = w_busy;
    assign o_drv_start      = r_drv_start;
    assign o_drv_pulseWidth = r_drv_pw;
    assign o_overrun        = r_overrun;
    assign o_err            = r_err;

    always_comb begin
        o_servo_pulse = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            o_servo_pulse[i] = w_route && (r_ch == CH_W'(i)) && i_drv_pulse;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_frame_cnt <= '0;
            r_alive     <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (!i_enable || r_frame_cnt == 32'(FRAME_CYCLES - 1)) begin
                r_frame_cnt <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_timer     <= '0;
            r_drv_start <= 1'b0;
            r_drv_pw    <= '0;
            r_overrun   <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_target[i]    <= pw_t'(CENTER_PW);
                r_committed[i] <= pw_t'(CENTER_PW);
            end
        end else begin
            r_drv_start <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (i_pos_wr && i_pos_ch == CH_W'(i)) begin
                    r_target[i] <= i_pos_data;
                end
            end
            if (w_tick && w_busy) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (i_enable) r_state <= S_WAIT_FRAME;
                end
                S_WAIT_FRAME: begin
                    if (!i_enable)  r_state <= S_IDLE;
                    else if (w_tick) r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        r_committed[i] <= w_next[i];
                    end
                    r_ch    <= '0;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!i_enable) begin
                        r_state <= S_IDLE;
                    end else if (i_drv_done) begin
                        r_drv_start <= 1'b1;
                        r_drv_pw    <= r_committed[r_ch];
                        r_timer     <= '0;
                        r_state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!i_drv_done) begin
                        r_state <= S_RUN;
                    end else if (r_timer == TW'(DONE_TIMEOUT - 1)) begin
                        r_err <= 1'b1;
                        if (w_last) begin
                            r_state <= i_enable ? S_WAIT_FRAME : S_IDLE;
                        end else begin
                            r_ch    <= r_ch + 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RUN: begin
                    // Channel only advances once the pulse has ended.
                    if (i_drv_done) begin
                        if (w_last) begin
                            r_state <= i_enable ? S_WAIT_FRAME : S_IDLE;
                        end else begin
                            r_ch    <= r_ch + 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_scheduler.sv
// Directed bench for servo_scheduler with a behavioural servo driver
// that can also act as a stuck-idle or slow-to-finish stub.
module tb_servo_scheduler;

    localparam int FRAME = 2000;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        pos_wr;
    logic [0:0]  pos_ch;
    logic [31:0] pos_data;
    logic        drv_start;
    logic [31:0] drv_pw;
    logic        drv_done;
    logic        drv_pulse;
    logic [1:0]  servo;
    logic        frame_start;
    logic        busy;
    logic        overrun;
    logic        err;

    int n_cmp;
    int n_bad;
    int cyc;
    int last_tick;
    int mode;
    int dcnt;
    int start_tot;
    int start_base;
    int last_start_cyc;
    int err_delta;
    int overlap;
    int hcnt0;
    int hcnt1;
    int q0[$];
    int q1[$];
    bit err_seen;

    servo_scheduler #(
        .NUM_CH       (2),
        .FRAME_CYCLES (FRAME),
        .MIN_PW       (100),
        .MAX_PW       (200),
        .CENTER_PW    (150),
        .SLEW_STEP    (10),
        .DONE_TIMEOUT (4)
    ) dut (
        .i_clk            (clk),
        .i_rstn           (rst_n),
        .i_enable         (en),
        .i_pos_wr         (pos_wr),
        .i_pos_ch         (pos_ch),
        .i_pos_data       (pos_data),
        .o_drv_start      (drv_start),
        .o_drv_pulseWidth (drv_pw),
        .i_drv_done       (drv_done),
        .i_drv_pulse      (drv_pulse),
        .o_servo_pulse    (servo),
        .o_frame_start    (frame_start),
        .o_busy           (busy),
        .o_overrun        (overrun),
        .o_err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Driver model: mode 0 real, 1 done stuck high, 2 done low ~2500 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_done  <= 1'b1;
            drv_pulse <= 1'b0;
            dcnt      <= 0;
        end else if (mode == 1) begin
            drv_done  <= 1'b1;
            drv_pulse <= 1'b0;
        end else if (drv_start) begin
            drv_done <= 1'b0;
            if (mode == 2) begin
                drv_pulse <= 1'b0;
                dcnt      <= 2500;
            end else begin
                drv_pulse <= 1'b1;
                dcnt      <= int'(drv_pw) - 1;
            end
        end else if (!drv_done) begin
            if (dcnt > 0) begin
                dcnt <= dcnt - 1;
            end else begin
                drv_pulse <= 1'b0;
                drv_done  <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (servo[0]) hcnt0 = hcnt0 + 1;
        else if (hcnt0 > 0) begin q0.push_back(hcnt0); hcnt0 = 0; end
        if (servo[1]) hcnt1 = hcnt1 + 1;
        else if (hcnt1 > 0) begin q1.push_back(hcnt1); hcnt1 = 0; end
        if (&servo) overlap = overlap + 1;
        if (drv_start) begin
            start_tot      = start_tot + 1;
            last_start_cyc = cyc;
        end
        if (err && !err_seen) begin
            err_seen  = 1'b1;
            err_delta = cyc - last_start_cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic ch, input logic [31:0] d);
        @(posedge clk);
        #1;
        pos_wr   = 1'b1;
        pos_ch   = ch;
        pos_data = d;
        @(posedge clk);
        #1;
        pos_wr = 1'b0;
    endtask

    task automatic wait_tick(input bit iv);
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_start && n < 2600) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) check("tick_timeout", 32'(n), 32'd0);
        if (iv) check("frame_period", 32'(cyc - last_tick), 32'(FRAME));
        last_tick  = cyc;
        start_base = start_tot;
        q0.delete();
        q1.delete();
    endtask

    task automatic do_frame(input bit iv, output int w0, output int w1);
        wait_tick(iv);
        repeat (400) @(negedge clk);
        w0 = (q0.size() == 1) ? q0[0] : -1;
        w1 = (q1.size() == 1) ? q1[0] : -1;
    endtask

    task automatic wait_p0();
        int n;
        n = 0;
        while (!servo[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!servo[0]) check("p0_timeout", 32'(n), 32'd0);
    endtask

    int w0;
    int w1;
    int e0[4] = '{160, 170, 180, 180};

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; last_tick = 0; mode = 0;
        start_tot = 0; start_base = 0; last_start_cyc = 0;
        err_delta = -1; err_seen = 1'b0; overlap = 0; hcnt0 = 0; hcnt1 = 0;
        rst_n = 1'b0; en = 1'b0; pos_wr = 1'b0; pos_ch = 1'b0; pos_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_pw", drv_pw, 0);
        check("rst_start", 32'(drv_start), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);

        do_frame(1'b0, w0, w1);
        check("center_ch0", 32'(w0), 150);
        check("center_ch1", 32'(w1), 150);
        check("center_pw_out", drv_pw, 150);

        wr(1'b0, 32'd180);
        for (int f = 0; f < 4; f++) begin
            do_frame(1'b1, w0, w1);
            check($sformatf("slew_up_ch0_f%0d", f), 32'(w0), 32'(e0[f]));
            check($sformatf("slew_up_ch1_f%0d", f), 32'(w1), 150);
        end

        wr(1'b1, 32'd50);
        for (int f = 0; f < 6; f++) begin
            do_frame(1'b1, w0, w1);
            check($sformatf("low_clamp_ch1_f%0d", f), 32'(w1),
                  32'((150 - 10 * (f + 1) < 100) ? 100 : 150 - 10 * (f + 1)));
        end
        check("low_clamp_ch0", 32'(w0), 180);

        wr(1'b1, 32'hFFFF_FFFF);
        for (int f = 0; f < 11; f++) begin
            do_frame(1'b1, w0, w1);
            check($sformatf("high_clamp_ch1_f%0d", f), 32'(w1),
                  32'((100 + 10 * (f + 1) > 200) ? 200 : 100 + 10 * (f + 1)));
        end
        check("no_overlap", 32'(overlap), 0);
        check("err_before_stub", 32'(err), 0);

        mode = 1;
        do_frame(1'b1, w0, w1);
        check("stub_err_set", 32'(err), 1);
        check("stub_err_delay", 32'(err_delta), 4);
        check("stub_starts", 32'(start_tot - start_base), 2);
        check("stub_no_pulse", 32'(q0.size() + q1.size()), 0);
        check("ovr_before_slow", 32'(overrun), 0);

        mode = 2;
        wait_tick(1'b1);
        begin
            int n;
            n = 0;
            while (start_tot == start_base && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("slow_start_seen", 32'(start_tot - start_base), 1);
        end
        @(posedge clk);
        #1;
        mode = 0;
        wait_tick(1'b1);
        @(negedge clk);
        check("slow_overrun", 32'(overrun), 1);
        do_frame(1'b1, w0, w1);
        check("after_ovr_ch0", 32'(w0), 180);
        check("after_ovr_ch1", 32'(w1), 200);

        wait_tick(1'b1);
        wait_p0();
        repeat (20) @(negedge clk);
        en = 1'b0;
        begin
            int n;
            n = 0;
            while (q0.size() == 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("dis_ch0_width", 32'(q0.size() == 1 ? q0[0] : -1), 180);
        repeat (5) @(negedge clk);
        check("dis_no_ch1", 32'(start_tot - start_base), 1);
        check("dis_busy", 32'(busy), 0);
        check("dis_pins", 32'(servo), 0);

        en = 1'b1;
        wait_tick(1'b0);
        wait_p0();
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pins", 32'(servo), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_start", 32'(drv_start), 0);
        check("mid_rst_pw", drv_pw, 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_ovr", 32'(overrun), 0);
        check("mid_rst_tick", 32'(frame_start), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
